m_dmux_stream: RTL and testbench
================================

Name: m_dmux_stream

Overview:
- Parametrised, registered 1-to-N demultiplexer for WIDTH-bit data words, with a valid/ready handshake on the input and on every output channel.
- Routes each accepted word to the channel given by i_sel. A broadcast mode sends one word to all channels at once.
- Each channel holds one word in its own register. A stalled channel does not block traffic to the other channels.
- Sits between a single producer (for example the ALU/bus result path) and N consumers (registers, memory-mapped devices).

Parameters:
WIDTH, 16, data word width in bits (>=1)
CHANNELS, 4, number of output channels (>=2)
SEL_W, 2, width of i_sel; must satisfy 2**SEL_W >= CHANNELS

Ports:
i_clk  input  1  system clock, rising-edge
i_rst  input  1  asynchronous, active-high reset
i_in  input  WIDTH  input data word
i_valid  input  1  input word valid
o_ready  output  1  block can accept a word this cycle
i_sel  input  SEL_W  destination channel index
i_bcast  input  1  broadcast: route word to all channels, i_sel ignored
o_data  output  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
o_valid  output  CHANNELS  channel k holds a valid word
i_ready  input  CHANNELS  consumer k accepts its word this cycle
o_err  output  1  one-cycle pulse: an out-of-range word was accepted and dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_valid = 0, every o_data slice = 0, o_err = 0. Reset asserted mid-operation discards all buffered words immediately, with no clock needed.
- Channel free term: free[k] = !o_valid[k] | i_ready[k]. A full channel that drains this cycle counts as free.
- o_ready is combinational and depends only on current inputs and state:
  - i_bcast = 1: o_ready = AND of free[k] over all k.
  - i_bcast = 0 and i_sel < CHANNELS: o_ready = free[i_sel].
  - i_bcast = 0 and i_sel >= CHANNELS: o_ready = 1 (word is sunk).
- Accept: accept = i_valid & o_ready, sampled on the rising edge of i_clk.
- Latency: an accepted word appears on its target channel(s) with o_valid set on the next cycle. There is no combinational path from i_in to o_data.
- Per-channel update on each clock edge:
  - Channel targeted by an accept: load i_in into o_data[k] and set o_valid[k] = 1. This applies even if the channel drains in the same cycle (back-to-back throughput is 1 word/cycle per channel).
  - Channel not targeted, with o_valid[k] & i_ready[k]: clear o_valid[k]. o_data[k] holds its last value.
  - Otherwise: hold state.
- Output stability: while o_valid[k] = 1 and i_ready[k] = 0, o_data[k] and o_valid[k] must not change.
- Consumer handshake: i_ready[k] while o_valid[k] = 0 has no effect.
- Broadcast: is all-or-nothing. No channel loads unless every channel is free. All channels load the same word in the same cycle.
- Out-of-range index: an accept with i_bcast = 0 and i_sel >= CHANNELS (possible only when CHANNELS < 2**SEL_W) loads no channel. o_err = 1 for exactly the next cycle. o_err is 0 in all other cycles, including when i_valid = 0 with an out-of-range i_sel.
- Independence: a stalled channel never affects o_ready for a word addressed to a different free channel.
- Producer side: i_valid may rise and fall freely. If i_valid = 1 and o_ready = 0, the producer must hold the word stable, and the block does not consume it.
- Parameter check: elaboration must fail (generate-time error) if 2**SEL_W < CHANNELS.

Test Plan:
1. Reset and routing (default params): after reset, o_valid = 4'b0000 and o_data = 0. Send 16'hA5A5 with i_sel = 2 and i_ready = 4'b0000. Next cycle o_valid = 4'b0100 and channel 2 data = A5A5, other slices unchanged.
2. Stall and independence: channel 2 full and stalled. Offer 16'h1111 to sel = 2 → o_ready = 0, nothing changes. Offer 16'h2222 to sel = 0 in the same stall → accepted, next cycle o_valid = 4'b0101, channel 2 still A5A5.
3. Drain and load in the same cycle: channel 1 holds 16'h0001 with i_ready[1] = 1, and 16'h0002 is offered to sel = 1 → o_ready = 1. Next cycle o_valid[1] = 1 and channel 1 = 0002. Streaming 8 words to channel 1 with i_ready[1] held high gives 1 word/cycle with no bubbles.
4. Broadcast: channel 3 full and stalled. Broadcast 16'hBEEF → o_ready = 0. Release i_ready[3] → accepted. Next cycle o_valid = 4'b1111 and all slices = BEEF.
5. Out-of-range (CHANNELS = 3, SEL_W = 2): send 16'hDEAD with sel = 3 → o_ready = 1, o_valid unchanged, o_err = 1 for one cycle. The same sel with i_valid = 0 → o_err stays 0.
6. Async reset mid-operation: channels 0 and 2 full. Assert i_rst between clock edges → o_valid = 0 and o_data = 0 immediately. After release, normal routing resumes on the first accepted word.

Source files
------------

// File: rtl/m_dmux_stream.sv
// m_dmux_stream: registered 1-to-N stream demultiplexer with per-channel
// one-word buffers, broadcast mode and out-of-range drop reporting.
module m_dmux_stream #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [WIDTH-1:0]          i_in,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_bcast,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    output logic [CHANNELS-1:0]       o_valid,
    input  logic [CHANNELS-1:0]       i_ready,
    output logic                      o_err
);

    // Refuse to elaborate when i_sel cannot address every channel.
    if ((2 ** SEL_W) < CHANNELS) begin : g_param_check
        $error("m_dmux_stream: 2**SEL_W must be >= CHANNELS");
    end

    // CHANNELS fits in SEL_W+1 bits because 2**SEL_W >= CHANNELS.
    localparam logic [SEL_W:0] ChanLim = (SEL_W + 1)'(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS-1:0]       valid_q;
    logic                      err_q;

    logic [CHANNELS-1:0]       free;
    logic [CHANNELS-1:0]       sel_hit;
    logic [CHANNELS-1:0]       load;
    logic                      in_range;
    logic                      accept;

    // Channel availability, destination decode and the input handshake.
    always_comb begin
        free     = ~valid_q | i_ready;
        sel_hit  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hit[k] = (i_sel == SEL_W'(k));
        end
        in_range = ({1'b0, i_sel} < ChanLim);
        if (i_bcast) begin
            o_ready = &free;
        end else if (in_range) begin
            o_ready = |(sel_hit & free);
        end else begin
            o_ready = 1'b1;  // out-of-range words are sunk
        end
        accept = i_valid & o_ready;
        load   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            load[k] = accept & (i_bcast | sel_hit[k]);
        end
    end

    // Per-channel buffers: load wins over drain so a channel sustains 1 word/cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    data_q[k*WIDTH +: WIDTH] <= i_in;
                    valid_q[k]               <= 1'b1;
                end else if (valid_q[k] && i_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // One-cycle pulse when an accepted word had no channel to go to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~i_bcast & ~in_range;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_m_dmux_stream.sv
// Testbench for m_dmux_stream: a 4-channel and a 3-channel instance, each
// shadowed by a behavioural model of the routing rules.
module tb_m_dmux_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] in4, in3;
    logic        valid4, valid3;
    logic        bcast4, bcast3;
    logic [1:0]  sel4, sel3;
    logic [3:0]  ready4;
    logic [2:0]  ready3;
    logic        o_ready4, o_ready3;
    logic [63:0] o_data4;
    logic [47:0] o_data3;
    logic [3:0]  o_valid4;
    logic [2:0]  o_valid3;
    logic        o_err4, o_err3;

    int checks = 0;
    int errors = 0;

    // Model state per instance (index 0: 4 channels, index 1: 3 channels).
    bit          mv [2][4];
    logic [15:0] md [2][4];
    bit          me [2];
    // Inputs applied to each instance this cycle.
    bit          iv [2];
    int          is [2];
    bit          ib [2];
    logic [3:0]  ir [2];
    logic [15:0] id [2];

    always #5 clk = ~clk;

    m_dmux_stream dut4 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_in    (in4),
        .i_valid (valid4),
        .o_ready (o_ready4),
        .i_sel   (sel4),
        .i_bcast (bcast4),
        .o_data  (o_data4),
        .o_valid (o_valid4),
        .i_ready (ready4),
        .o_err   (o_err4)
    );

    m_dmux_stream #(
        .WIDTH    (16),
        .CHANNELS (3),
        .SEL_W    (2)
    ) dut3 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_in    (in3),
        .i_valid (valid3),
        .o_ready (o_ready3),
        .i_sel   (sel3),
        .i_bcast (bcast3),
        .o_data  (o_data3),
        .o_valid (o_valid3),
        .i_ready (ready3),
        .o_err   (o_err3)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nch(input int w);
        return (w == 0) ? 4 : 3;
    endfunction

    // A word can go if every channel it targets is empty or being emptied.
    function automatic bit model_ready(input int w);
        bit r;
        if (ib[w]) begin
            r = 1;
            for (int k = 0; k < nch(w); k++) r = r & (!mv[w][k] || ir[w][k]);
        end else if (is[w] < nch(w)) begin
            r = !mv[w][is[w]] || ir[w][is[w]];
        end else begin
            r = 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_valid(input int w);
        logic [3:0] v = '0;
        for (int k = 0; k < nch(w); k++) v[k] = mv[w][k];
        return v;
    endfunction

    function automatic logic [3:0] obs_valid(input int w);
        return (w == 0) ? o_valid4 : {1'b0, o_valid3};
    endfunction

    function automatic logic [15:0] obs_data(input int w, input int k);
        return (w == 0) ? o_data4[k*16 +: 16] : o_data3[k*16 +: 16];
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            me[w] = 0;
            for (int k = 0; k < 4; k++) begin
                mv[w][k] = 0;
                md[w][k] = '0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int w = 0; w < 2; w++) begin
            check_eq($sformatf("%s valid[%0d]", tag, w), obs_valid(w), model_valid(w));
            check_eq($sformatf("%s err[%0d]", tag, w), (w == 0) ? o_err4 : o_err3, me[w]);
            for (int k = 0; k < nch(w); k++)
                check_eq($sformatf("%s data[%0d][%0d]", tag, w, k), obs_data(w, k), md[w][k]);
        end
    endtask

    // One clock cycle: drive instance w (the other idles), check o_ready
    // before the edge, advance the model, check outputs after the edge.
    task automatic cycle(input int w, input bit vld, input int sel, input bit bc,
                         input logic [3:0] rdy, input logic [15:0] din);
        bit acc [2];
        for (int u = 0; u < 2; u++) begin
            iv[u] = (u == w) ? vld : 1'b0;
            is[u] = (u == w) ? sel : 0;
            ib[u] = (u == w) ? bc : 1'b0;
            ir[u] = (u == w) ? rdy : 4'b0000;
            id[u] = (u == w) ? din : 16'h0;
        end
        in4 = id[0]; valid4 = iv[0]; sel4 = is[0][1:0]; bcast4 = ib[0]; ready4 = ir[0];
        in3 = id[1]; valid3 = iv[1]; sel3 = is[1][1:0]; bcast3 = ib[1]; ready3 = ir[1][2:0];
        #3;
        check_eq("o_ready", (w == 0) ? o_ready4 : o_ready3, model_ready(w));
        for (int u = 0; u < 2; u++) acc[u] = iv[u] && model_ready(u);
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < nch(u); k++) begin
                if (acc[u] && (ib[u] || is[u] == k)) begin
                    mv[u][k] = 1;
                    md[u][k] = id[u];
                end else if (mv[u][k] && ir[u][k]) begin
                    mv[u][k] = 0;
                end
            end
            me[u] = acc[u] && !ib[u] && (is[u] >= nch(u));
        end
        compare_all("cyc");
    endtask

    initial begin
        in4 = '0; valid4 = 0; sel4 = '0; bcast4 = 0; ready4 = '0;
        in3 = '0; valid3 = 0; sel3 = '0; bcast3 = 0; ready3 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check_eq("reset valid4", o_valid4, 4'b0000);
        check_eq("reset data4", o_data4, 64'h0);
        rst = 0;

        // Routing to one channel.
        cycle(0, 1, 2, 0, 4'b0000, 16'hA5A5);
        check_eq("t1 valid", o_valid4, 4'b0100);
        check_eq("t1 ch2", o_data4[47:32], 16'hA5A5);

        // Stalled channel 2 does not block channel 0.
        cycle(0, 1, 2, 0, 4'b0000, 16'h1111);
        check_eq("t2 stall ch2", o_data4[47:32], 16'hA5A5);
        cycle(0, 1, 0, 0, 4'b0000, 16'h2222);
        check_eq("t2 valid", o_valid4, 4'b0101);

        // Drain and reload in the same cycle, then stream 8 words to channel 1.
        cycle(0, 1, 1, 0, 4'b0000, 16'h0001);
        cycle(0, 1, 1, 0, 4'b0010, 16'h0002);
        check_eq("t3 ch1", o_data4[31:16], 16'h0002);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 1, 0, 4'b0010, 16'h0100 + 16'(i));
            check_eq("t3 stream", {o_valid4[1], o_data4[31:16]}, {1'b1, 16'h0100 + 16'(i)});
        end

        // Broadcast is all-or-nothing.
        cycle(0, 1, 3, 0, 4'b0000, 16'h3333);
        cycle(0, 0, 0, 0, 4'b0111, 16'h0000);
        cycle(0, 1, 0, 1, 4'b0000, 16'hBEEF);
        check_eq("t4 blocked", o_valid4, 4'b1000);
        cycle(0, 1, 0, 1, 4'b1000, 16'hBEEF);
        check_eq("t4 valid", o_valid4, 4'b1111);
        check_eq("t4 data", o_data4, {4{16'hBEEF}});
        cycle(0, 0, 0, 0, 4'b1111, 16'h0000);

        // Out-of-range index on the 3-channel instance.
        cycle(1, 1, 3, 0, 4'b0000, 16'hDEAD);
        check_eq("t5 err", o_err3, 1'b1);
        check_eq("t5 valid", o_valid3, 3'b000);
        cycle(1, 0, 3, 0, 4'b0000, 16'hDEAD);
        check_eq("t5 err clr", o_err3, 1'b0);
        cycle(1, 0, 3, 0, 4'b0000, 16'hDEAD);

        // Asynchronous reset between clock edges.
        cycle(0, 1, 0, 0, 4'b0000, 16'h0A0A);
        cycle(0, 1, 2, 0, 4'b0000, 16'h0C0C);
        check_eq("t6 pre", o_valid4, 4'b0101);
        #2;
        rst = 1;
        #1;
        check_eq("t6 async valid", o_valid4, 4'b0000);
        check_eq("t6 async data", o_data4, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        compare_all("t6 after");
        cycle(0, 1, 1, 0, 4'b0000, 16'h7777);
        check_eq("t6 resume", {o_valid4, o_data4[31:16]}, {4'b0010, 16'h7777});

        // Randomized traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0), 4'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
